// File: rtl/mac_pipe_ctrl.sv
// Control path for the 4-stage MAC datapath: handshakes, per-stage valid/last/first tags, load enables, result flag.
// Define MAC_PIPE_PERF_EN to add the stall_cnt and bubble_cnt performance counters.
module mac_pipe_ctrl #(
    parameter int NEURON_CNT_W = 16,
    parameter int BEAT_CNT_W   = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    soft_clr,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    stage_1_en,
    output logic                    stage_2_en,
    output logic                    stage_3_en,
    output logic                    stage_4_en,
    output logic                    acc_clear,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [NEURON_CNT_W-1:0] neuron_cnt,
`ifdef MAC_PIPE_PERF_EN
    output logic [31:0]             stall_cnt,
    output logic [31:0]             bubble_cnt,
`endif
    output logic [BEAT_CNT_W-1:0]   beat_cnt
);

    function automatic logic [BEAT_CNT_W-1:0] f_beat_inc(input logic [BEAT_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    logic                    r_vld_p1, r_vld_p2, r_vld_p3;
    logic                    r_lst_p1, r_lst_p2, r_lst_p3;
    logic                    r_fst_p1, r_fst_p2, r_fst_p3;
    logic                    r_first;
    logic                    r_res_valid;
    logic [NEURON_CNT_W-1:0] r_neuron_cnt;
    logic [BEAT_CNT_W-1:0]   r_beat_cnt;
    logic                    w_adv;
    logic                    w_go;
    logic                    w_res_hs;

    // The whole pipe moves in lockstep; a held result freezes every stage.
    always_comb begin
        w_adv      = !r_res_valid || res_ready;
        w_go       = w_adv && !soft_clr;
        w_res_hs   = r_res_valid && res_ready;
        in_ready   = w_go;
        stage_1_en = in_valid && w_go;
        stage_2_en = r_vld_p1 && w_go;
        stage_3_en = r_vld_p2 && w_go;
        stage_4_en = r_vld_p3 && w_go;
        acc_clear  = stage_4_en && r_fst_p3;
    end

    assign res_valid  = r_res_valid;
    assign neuron_cnt = r_neuron_cnt;
    assign beat_cnt   = r_beat_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || soft_clr) begin
            r_vld_p1     <= 1'b0;
            r_vld_p2     <= 1'b0;
            r_vld_p3     <= 1'b0;
            r_lst_p1     <= 1'b0;
            r_lst_p2     <= 1'b0;
            r_lst_p3     <= 1'b0;
            r_fst_p1     <= 1'b0;
            r_fst_p2     <= 1'b0;
            r_fst_p3     <= 1'b0;
            r_first      <= 1'b1;
            r_res_valid  <= 1'b0;
            r_neuron_cnt <= '0;
            r_beat_cnt   <= '0;
        end else begin
            if (w_adv) begin
                // MULTIPLY -> ADDITION
                r_vld_p1 <= stage_1_en;
                r_lst_p1 <= in_last;
                r_fst_p1 <= r_first;
                // ADDITION -> SUM
                r_vld_p2 <= r_vld_p1;
                r_lst_p2 <= r_lst_p1;
                r_fst_p2 <= r_fst_p1;
                // SUM -> ACCUMULATE
                r_vld_p3 <= r_vld_p2;
                r_lst_p3 <= r_lst_p2;
                r_fst_p3 <= r_fst_p2;
            end
            if (stage_1_en) begin
                r_first    <= in_last;
                r_beat_cnt <= in_last ? '0 : f_beat_inc(r_beat_cnt);
            end
            // ACCUMULATE -> RESULT: a new capture wins over the handshake clear
            if (stage_4_en && r_lst_p3)
                r_res_valid <= 1'b1;
            else if (w_res_hs)
                r_res_valid <= 1'b0;
            if (w_res_hs)
                r_neuron_cnt <= r_neuron_cnt + 1'b1;
        end
    end

`ifdef MAC_PIPE_PERF_EN
    function automatic logic [31:0] f_perf_inc(input logic [31:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || soft_clr) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (!w_adv)
                r_stall_cnt <= f_perf_inc(r_stall_cnt);
            if (w_adv && !r_vld_p3)
                r_bubble_cnt <= f_perf_inc(r_bubble_cnt);
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_mac_pipe_ctrl.sv
// Directed bench for mac_pipe_ctrl: a slot-level model checked every cycle plus hand-computed cycle masks.
module tb_mac_pipe_ctrl;
    localparam int NW = 16;
    localparam int BW = 12;
    localparam int LOGN = 8192;

    logic          clk = 1'b0;
    logic          reset;
    logic          soft_clr;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          stage_1_en, stage_2_en, stage_3_en, stage_4_en;
    logic          acc_clear;
    logic          res_valid;
    logic          res_ready;
    logic [NW-1:0] neuron_cnt;
    logic [BW-1:0] beat_cnt;
`ifdef MAC_PIPE_PERF_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   bubble_cnt;
`endif

    always #5 clk = ~clk;

    mac_pipe_ctrl #(.NEURON_CNT_W(NW), .BEAT_CNT_W(BW)) dut (
        .clk(clk), .reset(reset), .soft_clr(soft_clr),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .stage_1_en(stage_1_en), .stage_2_en(stage_2_en),
        .stage_3_en(stage_3_en), .stage_4_en(stage_4_en),
        .acc_clear(acc_clear), .res_valid(res_valid), .res_ready(res_ready),
        .neuron_cnt(neuron_cnt),
`ifdef MAC_PIPE_PERF_EN
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
        .beat_cnt(beat_cnt)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Model: three beat slots between the input and the RESULT register.
    typedef struct packed {
        logic vld;
        logic lst;
        logic fst;
    } slot_t;

    slot_t         m_pipe [3];
    logic          m_f;
    logic          m_rv;
    logic [NW-1:0] m_ncnt;
    logic [BW-1:0] m_bcnt;
    logic [31:0]   m_stall;
    logic [31:0]   m_bubble;

    logic          s1_log  [LOGN];
    logic          s4_log  [LOGN];
    logic          acc_log [LOGN];
    logic          rv_log  [LOGN];
    logic          ir_log  [LOGN];
    logic [BW-1:0] bc_log  [LOGN];
    int            gcyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, gcyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = '0;
        m_f      = 1'b1;
        m_rv     = 1'b0;
        m_ncnt   = '0;
        m_bcnt   = '0;
        m_stall  = '0;
        m_bubble = '0;
    endtask

    task automatic compare_and_advance(input bit was_rst);
        logic adv, go, acc_in, cap;
        if (reset || was_rst) model_reset();
        adv    = !m_rv || res_ready;
        go     = adv && !soft_clr;
        acc_in = in_valid && go;
        chk("in_ready",   32'(in_ready),   32'(go));
        chk("stage_1_en", 32'(stage_1_en), 32'(acc_in));
        chk("stage_2_en", 32'(stage_2_en), 32'(m_pipe[0].vld && go));
        chk("stage_3_en", 32'(stage_3_en), 32'(m_pipe[1].vld && go));
        chk("stage_4_en", 32'(stage_4_en), 32'(m_pipe[2].vld && go));
        chk("acc_clear",  32'(acc_clear),  32'(m_pipe[2].vld && go && m_pipe[2].fst));
        chk("res_valid",  32'(res_valid),  32'(m_rv));
        chk("neuron_cnt", 32'(neuron_cnt), 32'(m_ncnt));
        chk("beat_cnt",   32'(beat_cnt),   32'(m_bcnt));
`ifdef MAC_PIPE_PERF_EN
        chk("stall_cnt",  stall_cnt,  m_stall);
        chk("bubble_cnt", bubble_cnt, m_bubble);
`endif
        s1_log[gcyc]  = stage_1_en;
        s4_log[gcyc]  = stage_4_en;
        acc_log[gcyc] = acc_clear;
        rv_log[gcyc]  = res_valid;
        ir_log[gcyc]  = in_ready;
        bc_log[gcyc]  = beat_cnt;
        gcyc++;
        if (reset) return;
        if (soft_clr) begin
            model_reset();
            return;
        end
        if (!adv && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (adv && !m_pipe[2].vld && m_bubble != 32'hFFFF_FFFF) m_bubble++;
        cap = adv && m_pipe[2].vld && m_pipe[2].lst;
        if (m_rv && res_ready) begin
            m_ncnt++;
            m_rv = 1'b0;
        end
        if (cap) m_rv = 1'b1;
        if (adv) begin
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = '{vld: acc_in, lst: in_last, fst: m_f};
        end
        if (acc_in) begin
            m_f = in_last;
            if (in_last) m_bcnt = '0;
            else if (m_bcnt != {BW{1'b1}}) m_bcnt++;
        end
    endtask

    task automatic cycle(input logic v, input logic l, input logic rr, input logic sc);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_last   = l;
        res_ready = rr;
        soft_clr  = sc;
        @(negedge clk);
        compare_and_advance(1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic rst_pulse_cycle();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b1;
        soft_clr  = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_in_ready",  32'(in_ready),   32'd1);
        chk("rst_s4",        32'(stage_4_en), 32'd0);
        chk("rst_s2",        32'(stage_2_en), 32'd0);
        chk("rst_res_valid", 32'(res_valid),  32'd0);
        chk("rst_ncnt",      32'(neuron_cnt), 32'd0);
        chk("rst_bcnt",      32'(beat_cnt),   32'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        compare_and_advance(1'b1);
    endtask

    function automatic logic [15:0] mask_of(input int which, input int t0);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            case (which)
                0:       m[i] = s1_log[t0+i];
                1:       m[i] = s4_log[t0+i];
                2:       m[i] = acc_log[t0+i];
                3:       m[i] = rv_log[t0+i];
                default: m[i] = ir_log[t0+i];
            endcase
        end
        return m;
    endfunction

    initial begin
        int t0;
        reset     = 1'b1;
        soft_clr  = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Single 3-beat neuron
        t0 = gcyc;
        cycle(1, 0, 1, 0); cycle(1, 0, 1, 0); cycle(1, 1, 1, 0);
        idle(14);
        chk("t1_s1_mask",  32'(mask_of(0, t0)), 32'h0007);
        chk("t1_s4_mask",  32'(mask_of(1, t0)), 32'h0038);
        chk("t1_acc_mask", 32'(mask_of(2, t0)), 32'h0008);
        chk("t1_rv_mask",  32'(mask_of(3, t0)), 32'h0040);
        chk("t1_bc_c2",    32'(bc_log[t0+2]),   32'd2);
        chk("t1_ncnt",     32'(neuron_cnt),     32'd1);

        // Back-to-back single-beat neurons
        cycle(0, 0, 1, 1);
        t0 = gcyc;
        for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0);
        idle(13);
        chk("t2_s4_mask",  32'(mask_of(1, t0)), 32'h0078);
        chk("t2_acc_mask", 32'(mask_of(2, t0)), 32'h0078);
        chk("t2_rv_mask",  32'(mask_of(3, t0)), 32'h00F0);
        chk("t2_ncnt",     32'(neuron_cnt),     32'd4);

        // Backpressure: 2-beat then 1-beat neuron, res_ready low cycles 4-9
        cycle(0, 0, 1, 1);
        t0 = gcyc;
        cycle(1, 0, 1, 0); cycle(1, 1, 1, 0); cycle(1, 1, 1, 0); cycle(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
        idle(10);
        chk("t3_ir_mask",  32'(mask_of(4, t0)), 32'hFC1F);
        chk("t3_s4_mask",  32'(mask_of(1, t0)), 32'h0418);
        chk("t3_acc_mask", 32'(mask_of(2, t0)), 32'h0408);
        chk("t3_rv_mask",  32'(mask_of(3, t0)), 32'h0FE0);
        chk("t3_ncnt",     32'(neuron_cnt),     32'd2);
`ifdef MAC_PIPE_PERF_EN
        chk("t3_stall",    stall_cnt,           32'd5);
`endif

        // Handshake coinciding with a new last capture
        cycle(0, 0, 1, 1);
        t0 = gcyc;
        cycle(1, 0, 1, 0); cycle(1, 1, 1, 0); cycle(1, 1, 1, 0);
        cycle(0, 0, 1, 0); cycle(0, 0, 1, 0); cycle(0, 0, 0, 0);
        idle(12);
        chk("t4_ir_mask",  32'(mask_of(4, t0)), 32'hFFDF);
        chk("t4_s4_mask",  32'(mask_of(1, t0)), 32'h0058);
        chk("t4_acc_mask", 32'(mask_of(2, t0)), 32'h0048);
        chk("t4_rv_mask",  32'(mask_of(3, t0)), 32'h00E0);
        chk("t4_ncnt",     32'(neuron_cnt),     32'd2);

        // soft_clr with three beats in flight, then a fresh single-beat neuron
        cycle(0, 0, 1, 1);
        t0 = gcyc;
        cycle(1, 0, 1, 0); cycle(1, 0, 1, 0); cycle(1, 0, 1, 0);
        cycle(0, 0, 1, 1); cycle(0, 0, 1, 0); cycle(1, 1, 1, 0);
        idle(12);
        chk("t5_bc_c3",    32'(bc_log[t0+3]),   32'd3);
        chk("t5_bc_c4",    32'(bc_log[t0+4]),   32'd0);
        chk("t5_s4_mask",  32'(mask_of(1, t0)), 32'h0100);
        chk("t5_acc_mask", 32'(mask_of(2, t0)), 32'h0100);
        chk("t5_rv_mask",  32'(mask_of(3, t0)), 32'h0200);
        chk("t5_ncnt",     32'(neuron_cnt),     32'd1);

        // Asynchronous reset pulse during traffic
        cycle(1, 0, 1, 0); cycle(1, 0, 1, 0);
        rst_pulse_cycle();
        t0 = gcyc;
        cycle(1, 1, 1, 0);
        idle(15);
        chk("t6_s4_mask",  32'(mask_of(1, t0)), 32'h0008);
        chk("t6_acc_mask", 32'(mask_of(2, t0)), 32'h0008);
        chk("t6_rv_mask",  32'(mask_of(3, t0)), 32'h0010);
        chk("t6_ncnt",     32'(neuron_cnt),     32'd1);

        // Beat counter saturation on a very long neuron
        cycle(0, 0, 1, 1);
        for (int i = 0; i < 4100; i++) cycle(1, 0, 1, 0);
        chk("t7_bc_sat",   32'(beat_cnt),       32'h0FFF);
        cycle(1, 1, 1, 0);
        idle(6);
        chk("t7_bc_zero",  32'(beat_cnt),       32'd0);
        chk("t7_ncnt",     32'(neuron_cnt),     32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
